// File: rtl/regfile_wb_arbiter_if.sv
// Writeback-port bundle between the ALU/LSU/decode side and the register-file write arbiter.
// Latency: pure wiring, no storage.
// Backpressure: alu_ready/lsu_ready come back from the arbiter; requesters hold valid/rd/data until accepted.
interface regfile_wb_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    // ALU writeback request
    logic                  alu_valid;
    logic [ADDR_WIDTH-1:0] alu_rd;
    logic [DATA_WIDTH-1:0] alu_data;
    logic                  alu_ready;

    // LSU (load) writeback request
    logic                  lsu_valid;
    logic [ADDR_WIDTH-1:0] lsu_rd;
    logic [DATA_WIDTH-1:0] lsu_data;
    logic                  lsu_ready;

    // Decode side: issued destination and source-register hazard query
    logic                  iss_valid;
    logic [ADDR_WIDTH-1:0] iss_rd;
    logic [ADDR_WIDTH-1:0] rs1_addr;
    logic [ADDR_WIDTH-1:0] rs2_addr;
    logic                  rs_stall;

    // Registered register-file write port
    logic                  rf_we;
    logic [ADDR_WIDTH-1:0] rf_addr;
    logic [DATA_WIDTH-1:0] rf_data;

    // Pipeline side: drives requests, issue info and read addresses
    modport master (
        output alu_valid, alu_rd, alu_data,
        input  alu_ready,
        output lsu_valid, lsu_rd, lsu_data,
        input  lsu_ready,
        output iss_valid, iss_rd, rs1_addr, rs2_addr,
        input  rs_stall,
        input  rf_we, rf_addr, rf_data
    );

    // Arbiter side
    modport slave (
        input  alu_valid, alu_rd, alu_data,
        output alu_ready,
        input  lsu_valid, lsu_rd, lsu_data,
        output lsu_ready,
        input  iss_valid, iss_rd, rs1_addr, rs2_addr,
        output rs_stall,
        output rf_we, rf_addr, rf_data
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Shares the single register-file write port between ALU and LSU writeback and tracks pending destinations.
// Latency: grant at edge N drives rf_we/rf_addr/rf_data during cycle N+1; rs_stall is combinational.
// Backpressure: one non-x0 grant per cycle, LSU preferred until the ALU has lost STARVE_LIMIT times in a row.
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    regfile_wb_arbiter_if.slave bus
);

    localparam int                NUM_REGS = 1 << ADDR_WIDTH;
    localparam int                CNT_W    = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STARVE_LIMIT);

    logic                  alu_nz;
    logic                  lsu_nz;
    logic                  alu_win;
    logic                  lsu_win;
    logic                  grant_any;
    logic [ADDR_WIDTH-1:0] grant_rd;
    logic [DATA_WIDTH-1:0] grant_data;

    logic [CNT_W-1:0]      starve_cnt;
    logic [NUM_REGS-1:0]   pending;
    logic [NUM_REGS-1:0]   pending_nxt;

    logic                  rf_we_q;
    logic [ADDR_WIDTH-1:0] rf_addr_q;
    logic [DATA_WIDTH-1:0] rf_data_q;

    // Arbitration: x0 requests bypass the port; the ALU only beats a competing LSU once starved
    always_comb begin
        alu_nz     = bus.alu_valid && (bus.alu_rd != '0);
        lsu_nz     = bus.lsu_valid && (bus.lsu_rd != '0);
        alu_win    = alu_nz && (!lsu_nz || (starve_cnt == CNT_MAX));
        lsu_win    = lsu_nz && !alu_win;
        grant_any  = alu_win || lsu_win;
        grant_rd   = lsu_win ? bus.lsu_rd   : bus.alu_rd;
        grant_data = lsu_win ? bus.lsu_data : bus.alu_data;
    end

    // Ready means "accepted this cycle"; forced low while reset is held so nothing is consumed
    assign bus.alu_ready = rst_n && bus.alu_valid && (!alu_nz || alu_win);
    assign bus.lsu_ready = rst_n && bus.lsu_valid && (!lsu_nz || lsu_win);

    // Starvation counter: counts consecutive ALU losses, cleared by any ALU grant
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            starve_cnt <= '0;
        end else if (alu_win) begin
            starve_cnt <= '0;
        end else if (alu_nz && (starve_cnt != CNT_MAX)) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end

    // Registered write port: pulses for one cycle per grant, address/data hold otherwise
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rf_we_q   <= 1'b0;
            rf_addr_q <= '0;
            rf_data_q <= '0;
        end else begin
            rf_we_q <= grant_any;
            if (grant_any) begin
                rf_addr_q <= grant_rd;
                rf_data_q <= grant_data;
            end
        end
    end

    assign bus.rf_we   = rf_we_q;
    assign bus.rf_addr = rf_addr_q;
    assign bus.rf_data = rf_data_q;

    // Scoreboard update: grant clears, issue sets afterwards so a newer producer stays outstanding
    always_comb begin
        pending_nxt = pending;
        if (grant_any) begin
            pending_nxt[grant_rd] = 1'b0;
        end
        if (bus.iss_valid && (bus.iss_rd != '0)) begin
            pending_nxt[bus.iss_rd] = 1'b1;
        end
        pending_nxt[0] = 1'b0;
    end

    // Scoreboard register; cleared on reset so dropped producers never stall decode
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending <= '0;
        end else begin
            pending <= pending_nxt;
        end
    end

    // A granted write is cleared from the scoreboard at the grant edge; the register file's
    // write-first read covers the in-flight cycle, so only truly outstanding producers stall.
    assign bus.rs_stall = pending[bus.rs1_addr] | pending[bus.rs2_addr];

    // The write port never targets x0 and the scoreboard never tracks it
    a_no_x0_write: assert property (@(posedge clk) disable iff (!rst_n)
        bus.rf_we |-> (bus.rf_addr != '0));
    a_x0_never_pending: assert property (@(posedge clk) disable iff (!rst_n)
        pending[0] == 1'b0);

endmodule
